// File: rtl/div_n_if.sv
// Strobe-divider bus: count enable and requested ratio in, strobe, square and phase out.
interface div_n_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic [WIDTH-1:0] div;
  logic             q;
  logic             sq;
  logic [WIDTH-1:0] phase;

  modport master (output en, output div, input q, input sq, input phase);
  modport slave  (input en, input div, output q, output sq, output phase);
endinterface

// File: rtl/div_n.sv
// Parametrised clock-enable divider: one-cycle strobe every N enabled cycles, N from div (0 = 2^WIDTH).
// Define DIV_N_SQUARE_EN to build the ~50% duty square output; otherwise sq is tied low.
module div_n #(
  parameter int WIDTH = 3
) (
  input  logic    clk,
  input  logic    clear,
  div_n_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic             q_q, q_d;
  logic [WIDTH-1:0] term_cnt;
  logic             wrap;

  // ratio_q of zero wraps to all-ones, giving the full 2^WIDTH count range.
  assign term_cnt = ratio_q - WIDTH'(1);
  assign wrap     = (cnt_q == term_cnt);

  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    q_d     = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      ratio_d = bus.div;
      q_d     = 1'b1;
    end else if (bus.en) begin
      if (wrap) begin
        cnt_d   = '0;
        ratio_d = bus.div;
      end else begin
        cnt_d   = cnt_q + WIDTH'(1);
      end
      q_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q   <= '0;
      ratio_q <= bus.div;
      q_q     <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      q_q     <= q_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.phase = cnt_q;

`ifdef DIV_N_SQUARE_EN
  logic [WIDTH:0] ratio_eff;
  logic [WIDTH:0] half_cnt;
  logic           sq_q, sq_d;

  // ratio_d is the ratio governing cnt_d, so a wrap already sees the new div.
  always_comb begin
    ratio_eff = (ratio_d == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, ratio_d};
    half_cnt  = (ratio_eff >> 1) + (WIDTH + 1)'(ratio_eff[0]);
    sq_d      = sq_q;
    if (clear) begin
      sq_d = 1'b1;
    end else if (bus.en) begin
      sq_d = ({1'b0, cnt_d} < half_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sq_q <= 1'b1;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign bus.sq = sq_q;
`else
  assign bus.sq = 1'b0;
`endif

endmodule

// File: doc/div_n.md
# div_n

Parametrised integer clock-enable divider: generates a one-cycle strobe `q` every N enabled clock cycles, with N taken from a run-time `div` input of `WIDTH` bits. It succeeds the fixed 3-bit strobe divider and adds:
- arbitrary ratio width;
- glitch-free ratio changes at period boundaries;
- a count-enable;
- a phase output;
- an optional ~50% duty square output.

It sits in the clocking/strobe section and feeds enable pins of downstream sequential logic; its outputs are not used as clocks.

## Interface
- `WIDTH`, default 3 — width of `div`, the counter and `phase`; legal 1..16.
- `clk` in 1 — system clock, all logic on rising edge.
- `clear` in 1 — synchronous reset, active-high.
- `en` in 1 — count enable; counter advances only when high.
- `div` in WIDTH — requested ratio N; 0 encodes N = 2^WIDTH.
- `q` out 1 — strobe, registered, high for the one enabled cycle where `phase` = 0.
- `sq` out 1 — square output, registered (see Configuration).
- `phase` out WIDTH — current counter value.

## Operation
- Internal registers:
  - `cnt` (WIDTH bits, drives `phase`);
  - `ratio_q` (WIDTH bits, shadow of `div`);
  - `q`;
  - `sq`.
- Effective ratio R = `ratio_q` when nonzero, else 2^WIDTH. Compute it in WIDTH+1 bits.
- Terminal count T = R−1. Compute it as `ratio_q`−1 in WIDTH bits; 0 wraps naturally to all-ones.
- Cycle with `clear`=1:
  - `cnt` ← 0;
  - `ratio_q` ← `div`;
  - `q` ← 1;
  - `sq` ← 1.
  - `clear` overrides `en` and any period in progress.
- Cycle with `clear`=0, `en`=1:
  - If `cnt` = T: `cnt_next` = 0, and `ratio_q` ← `div` (new ratio adopted at the wrap).
  - Otherwise: `cnt_next` = `cnt`+1, and `ratio_q` holds.
  - Then `cnt` ← `cnt_next`, and `q` ← (`cnt_next` = 0).
  - `sq` ← (`cnt_next` < H), where H = (R'+1)>>1. R' is the ratio in force for `cnt_next`: the newly sampled `div` on a wrap, otherwise `ratio_q`.
- Cycle with `clear`=0, `en`=0:
  - `cnt`, `ratio_q` and `sq` hold;
  - `q` ← 0 (no strobe while paused).
  - When `en` returns, counting resumes from the held `cnt`. The period is measured in enabled cycles.
- Changing `div` mid-period has no effect until the next wrap, so the current period always completes at the old ratio.
- R = 1 (`div`=1): T = 0, `cnt` stays 0, and `q`=1 on every enabled cycle. `sq` is constant 1.
- R = 2^WIDTH (`div`=0): full-range count 0..2^WIDTH−1.
- No combinational path from any input to any output.

## Timing
- Reset values after a `clear` cycle: `q`=1, `sq`=1, `phase`=0.
- `q` first reasserts R enabled cycles after `clear` deasserts. Steady state: one high cycle per R enabled cycles.
- `phase` and `q` update on the same edge; `q` = 1 exactly when `phase` = 0 and the previous cycle was enabled (or was `clear`).
- `sq` in steady state, for R > 1: high for ceil(R/2) enabled cycles, low for floor(R/2); rising edge coincident with `q`.
- Ratio-change latency: a new `div` value is sampled on the wrap edge. It governs the period that starts on that edge.
- `clear` mid-period: the next edge forces the reset values regardless of `en`. No partial strobe is emitted afterwards.

## Configuration
- `DIV_N_SQUARE_EN` defined: the `sq` register, the H computation and the compare are built, and `sq` behaves as above.
- Not defined: that logic is omitted and `sq` is tied to 1'b0. The port remains, so instantiations are unchanged. `q` and `phase` are identical in both builds.

## Test plan
- `WIDTH`=3, `div`=1, `en`=1 after `clear` → `q`=1 every cycle, `phase`=0 throughout.
- `WIDTH`=3, `div`=3 → `q` sequence 1,0,0,1,0,0…, `phase` 0,1,2,0…
- `div`=5 running, switch `div` to 2 when `phase`=1 → remaining cycles `phase` 2,3,4, then 0,1,0,1; `q` high at each 0.
- `WIDTH`=3, `div`=0 → period 8, `phase` 0..7, one `q` per 8 cycles. `WIDTH`=8, `div`=0 → period 256.
- `div`=4, drop `en` for 3 cycles at `phase`=2 → `phase` holds 2, `q`=0, resume 3,0 with `q`=1 at 0.
- `DIV_N_SQUARE_EN` defined, `div`=5 → `sq` 1,1,1,0,0 repeating aligned to `q`.
  - Assert `clear` at `phase`=3 → next cycle `q`=1, `sq`=1, `phase`=0.
  - Without the macro → `sq` constantly 0.
